uart_tx_brg: RTL and testbench

UART transmitter paired with the auto-baud receive path. It sends 8N1 frames, LSB first, on UXTX. The bit period comes from the 8-bit baud value BRG_N produced by the auto-baud BRG register, so both directions of the link run at the detected rate. It sits beside the receiver/BRG datapath and is driven by a host-side start/busy/done handshake.

---
 rtl/uart_tx_brg.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_brg.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_brg.sv
// uart_tx_brg: 8N1 UART transmitter clocked by the auto-baud BRG value.
// Bit period is BRG_N+1 CLK cycles, latched when a frame is accepted.
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_brg #(
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           BRG_N,
  input  logic [DATA_BITS-1:0] TX_DATA,
  input  logic                 TX_START,
  output logic                 UXTX,
  output logic                 TX_BUSY,
  output logic                 TXIF
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] S_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] S_START  = 3'd1;
  localparam logic [ST_W-1:0] S_DATA   = 3'd2;
  localparam logic [ST_W-1:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [ST_W-1:0] S_PARITY = 3'd4;
`endif

  logic [ST_W-1:0]      state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [IDX_W-1:0]     idx_q,    idx_d;
  logic [DATA_BITS-1:0] shreg_q,  shreg_d;
  logic                 uxtx_q,   uxtx_d;
  logic                 busy_q,   busy_d;
  logic                 txif_q,   txif_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q,    par_d;
`endif

  logic tick_c;
  logic last_bit_c;

  assign tick_c     = (cnt_q == period_q);
  assign last_bit_c = (idx_q == IDX_W'(DATA_BITS - 1));

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    uxtx_d   = uxtx_q;
    busy_d   = busy_q;
    txif_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif

    if (state_q != S_IDLE) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        uxtx_d = IDLE_LEVEL;
        busy_d = 1'b0;
        if (TX_START) begin
          shreg_d  = TX_DATA;
          period_d = BRG_N;
          cnt_d    = '0;
          idx_d    = '0;
          uxtx_d   = ~IDLE_LEVEL;
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d    = ^TX_DATA;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (tick_c) begin
          state_d = S_DATA;
          idx_d   = '0;
          uxtx_d  = shreg_q[0];
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
          if (last_bit_c) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            uxtx_d  = par_q;
`else
            state_d = S_STOP;
            uxtx_d  = IDLE_LEVEL;
`endif
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            uxtx_d = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (tick_c) begin
          state_d = S_STOP;
          uxtx_d  = IDLE_LEVEL;
        end
      end
`endif
      S_STOP: begin
        if (tick_c) begin
          state_d = S_IDLE;
          txif_d  = 1'b1;
          busy_d  = 1'b0;
          uxtx_d  = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = S_IDLE;
        uxtx_d  = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs; reset returns the line to idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      uxtx_q   <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      txif_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      uxtx_q   <= uxtx_d;
      busy_q   <= busy_d;
      txif_q   <= txif_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign UXTX    = uxtx_q;
  assign TX_BUSY = busy_q;
  assign TXIF    = txif_q;

endmodule

// File: tb/tb_uart_tx_brg.sv
// Self-checking bench for uart_tx_brg: table vectors, corner sequences and
// random frames checked against a slot-level frame model.
module tb_uart_tx_brg;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] BRG_N;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       UXTX;
  logic       TX_BUSY;
  logic       TXIF;

`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_tx_brg dut (
    .CLK      (CLK),
    .RST      (RST),
    .BRG_N    (BRG_N),
    .TX_DATA  (TX_DATA),
    .TX_START (TX_START),
    .UXTX     (UXTX),
    .TX_BUSY  (TX_BUSY),
    .TXIF     (TXIF)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  brg;
    logic [7:0]  data;
    int          exp_len;
    logic [10:0] exp_slots;
  } vec_t;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, k, act, exp);
  endtask

  task automatic check_cycle(input string tag, input int k, input logic eu, input logic eb, input logic et);
    chk({tag, ".uxtx"}, k, 32'(UXTX), 32'(eu));
    chk({tag, ".busy"}, k, 32'(TX_BUSY), 32'(eb));
    chk({tag, ".txif"}, k, 32'(TXIF), 32'(et));
  endtask

  // Line level of each bit slot: start, data LSB first, optional parity, stop.
  function automatic logic [10:0] model_slots(input logic [7:0] d);
    logic [10:0] s;
    s    = '1;
    s[0] = 1'b0;
    for (int i = 0; i < 8; i++) s[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    s[9] = ^d;
`endif
    return s;
  endfunction

  // One frame from IDLE; optionally pulses a disturbing start/data/baud change at cycle disturb_k.
  task automatic run_frame(input string tag, input logic [7:0] n, input logic [7:0] d,
                           input int len, input logic [10:0] slots, input int disturb_k);
    TX_DATA  = d;
    BRG_N    = n;
    TX_START = 1'b1;
    for (int k = 0; k <= len + 2; k++) begin
      @(negedge CLK);
      if (k < len)       check_cycle(tag, k, slots[k / (int'(n) + 1)], 1'b1, 1'b0);
      else if (k == len) check_cycle(tag, k, 1'b1, 1'b0, 1'b1);
      else               check_cycle(tag, k, 1'b1, 1'b0, 1'b0);
      if (k == 0) TX_START = 1'b0;
      if (disturb_k >= 0 && k == disturb_k) begin
        TX_START = 1'b1;
        TX_DATA  = 8'hFF;
        BRG_N    = 8'd2;
      end
      if (disturb_k >= 0 && k == disturb_k + 1) TX_START = 1'b0;
    end
  endtask

  initial begin
    vec_t        tbl [4];
    logic [10:0] s1, s2;
    logic [7:0]  rn, rd;
    int          L, txif_cnt, t_first, t_second;

`ifdef UART_TX_PARITY_EN
    tbl[0] = '{8'd1, 8'h07, 22, {1'b1, 1'b1, 8'h07, 1'b0}};
    tbl[1] = '{8'd1, 8'h03, 22, {1'b1, 1'b0, 8'h03, 1'b0}};
    tbl[2] = '{8'd3, 8'hA5, 44, {1'b1, 1'b0, 8'hA5, 1'b0}};
    tbl[3] = '{8'd0, 8'h00, 11, {1'b1, 1'b0, 8'h00, 1'b0}};
`else
    tbl[0] = '{8'd3, 8'hA5, 40, {2'b11, 8'hA5, 1'b0}};
    tbl[1] = '{8'd0, 8'h00, 10, {2'b11, 8'h00, 1'b0}};
    tbl[2] = '{8'd1, 8'h0F, 20, {2'b11, 8'h0F, 1'b0}};
    tbl[3] = '{8'd7, 8'h55, 80, {2'b11, 8'h55, 1'b0}};
`endif

    RST = 1'b1; BRG_N = 8'd0; TX_DATA = 8'd0; TX_START = 1'b0;
    repeat (2) @(negedge CLK);
    check_cycle("reset", 0, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // Table vectors
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("tbl%0d", i), tbl[i].brg, tbl[i].data, tbl[i].exp_len, tbl[i].exp_slots, -1);

    // Asynchronous reset in the middle of data bit 3
    s1 = model_slots(8'hA5);
    TX_DATA = 8'hA5; BRG_N = 8'd3; TX_START = 1'b1;
    for (int k = 0; k <= 17; k++) begin
      @(negedge CLK);
      check_cycle("prerst", k, s1[k / 4], 1'b1, 1'b0);
      if (k == 0) TX_START = 1'b0;
    end
    RST = 1'b1;
    #1;
    check_cycle("midrst", 0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    check_cycle("midrst", 1, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    run_frame("postrst", 8'd3, 8'hA5, NSLOT * 4, model_slots(8'hA5), -1);

    // Start, data and baud changes while busy are ignored
    run_frame("ignore", 8'd7, 8'h55, NSLOT * 8, model_slots(8'h55), 20);

    // Back-to-back with TX_START held high
    L = NSLOT * 3;
    s1 = model_slots(8'h0F);
    s2 = model_slots(8'hF0);
    txif_cnt = 0; t_first = -1; t_second = -1;
    TX_DATA = 8'h0F; BRG_N = 8'd2; TX_START = 1'b1;
    for (int k = 0; k <= 2 * L + 4; k++) begin
      @(negedge CLK);
      if (k < L)              check_cycle("b2b", k, s1[k / 3], 1'b1, 1'b0);
      else if (k == L)        check_cycle("b2b", k, 1'b1, 1'b0, 1'b1);
      else if (k <= 2 * L)    check_cycle("b2b", k, s2[(k - L - 1) / 3], 1'b1, 1'b0);
      else if (k == 2 * L + 1) check_cycle("b2b", k, 1'b1, 1'b0, 1'b1);
      else                    check_cycle("b2b", k, 1'b1, 1'b0, 1'b0);
      if (TXIF) begin
        txif_cnt++;
        if (t_first < 0) t_first = k;
        else if (t_second < 0) t_second = k;
      end
      if (k == 0) TX_DATA = 8'hF0;
      if (k == L + 1) TX_START = 1'b0;
    end
    chk("b2b.txif_count", 0, 32'(txif_cnt), 32'd2);
    // TXIF cycle sits in IDLE, so the next start edge follows it by one cycle
    chk("b2b.spacing", 0, 32'(t_second - t_first), 32'(L + 1));

    // Random frames with random idle gaps
    for (int r = 0; r < 20; r++) begin
      rn = 8'($urandom_range(0, 4));
      rd = 8'($urandom);
      run_frame($sformatf("rnd%0d", r), rn, rd, NSLOT * (int'(rn) + 1), model_slots(rd), -1);
      repeat ($urandom_range(0, 3)) begin
        @(negedge CLK);
        check_cycle("gap", r, 1'b1, 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
